cfg_cmd_parser: RTL and testbench

Parses ASCII configuration commands arriving from the UART receiver and drives the configuration manager's command interface (config_valid/config_type/config_value1/config_value2). It is the initiator side of the config protocol. It waits for the manager's config_done/config_error pulse and returns a one-byte acknowledgement to the UART transmitter. It sits between uart_rx/uart_tx and the configuration manager.

---
 rtl/cfg_cmd_pkg.sv | 48 ++++
 rtl/cfg_cmd_parser_if.sv | 31 +++
 rtl/dec_accum.sv | 57 +++++
 rtl/cfg_cmd_parser.sv | 205 ++++++++++++++++++++
 tb/tb_cfg_cmd_parser.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_cmd_pkg.sv
// Shared constants, types and helpers for the ASCII config command parser
// and the configuration manager it drives.
package cfg_cmd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TYPE_W = 3;

  localparam logic [DATA_W-1:0] ASCII_C     = 8'h43;
  localparam logic [DATA_W-1:0] ASCII_MINUS = 8'h2D;
  localparam logic [DATA_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [DATA_W-1:0] ASCII_CR    = 8'h0D;
  localparam logic [DATA_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [DATA_W-1:0] ASCII_0     = 8'h30;
  localparam logic [DATA_W-1:0] ASCII_K     = 8'h4B;
  localparam logic [DATA_W-1:0] ASCII_E     = 8'h45;
  localparam logic [DATA_W-1:0] ASCII_T     = 8'h54;

  localparam logic [TYPE_W-1:0] CFG_TYPE_0 = 3'd0;
  localparam logic [TYPE_W-1:0] CFG_TYPE_1 = 3'd1;
  localparam logic [TYPE_W-1:0] CFG_TYPE_2 = 3'd2;
  localparam logic [TYPE_W-1:0] CFG_TYPE_3 = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_VAL1,
    ST_VAL2,
    ST_SKIP,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } parser_state_e;

  typedef struct packed {
    logic [TYPE_W-1:0] ctype;
    logic [DATA_W-1:0] value1;
    logic [DATA_W-1:0] value2;
  } cfg_cmd_t;

  function automatic logic is_digit(input logic [DATA_W-1:0] b);
    return (b >= ASCII_0) && (b <= ASCII_0 + 8'd9);
  endfunction

  function automatic logic is_term(input logic [DATA_W-1:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/cfg_cmd_parser_if.sv
// Bundle of UART rx/tx, config-manager and status signals around the parser.
// master = parser side, slave = surrounding UART / config manager side.
interface cfg_cmd_parser_if;
  import cfg_cmd_pkg::*;

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              config_valid;
  logic [TYPE_W-1:0] config_type;
  logic [DATA_W-1:0] config_value1;
  logic [DATA_W-1:0] config_value2;
  logic              config_done;
  logic              config_error;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              busy;

  modport master (
    input  rx_valid, rx_data, config_done, config_error, tx_ready,
    output config_valid, config_type, config_value1, config_value2,
           tx_valid, tx_data, busy
  );

  modport slave (
    output rx_valid, rx_data, config_done, config_error, tx_ready,
    input  config_valid, config_type, config_value1, config_value2,
           tx_valid, tx_data, busy
  );

endinterface

// File: rtl/dec_accum.sv
// Signed decimal accumulator: sign flag, digit count, range check and an
// 8-bit two's-complement result, all registered. Cleared per value.
module dec_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       neg_i,
  input  logic       push_i,
  input  logic [3:0] digit_i,
  output logic [7:0] value_o,
  output logic [1:0] cnt_o,
  output logic       neg_o,
  output logic       err_o
);

  logic [9:0] mag_q;
  logic [1:0] cnt_q;
  logic       neg_q;
  logic       err_q;
  logic [7:0] value_q;
  logic [9:0] mag_nxt_c;

  // Three digits peak at 999, so 10 bits never wrap.
  assign mag_nxt_c = 10'(mag_q * 10'd10) + 10'(digit_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
    end else if (clr_i) begin
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
    end else begin
      if (neg_i) begin
        neg_q <= 1'b1;
      end
      if (push_i) begin
        mag_q   <= mag_nxt_c;
        cnt_q   <= cnt_q + 2'd1;
        value_q <= neg_q ? 8'(10'd0 - mag_nxt_c) : 8'(mag_nxt_c);
        err_q   <= mag_nxt_c > (neg_q ? 10'd128 : 10'd127);
      end
    end
  end

  assign value_o = value_q;
  assign cnt_o   = cnt_q;
  assign neg_o   = neg_q;
  assign err_o   = err_q;

endmodule

// File: rtl/cfg_cmd_parser.sv
// ASCII "C<t> [v1 [v2]]<CR|LF>" parser driving the config manager and
// returning a K/E/T ack byte. CFG_PARSER_TIMEOUT_EN adds a WAIT timeout.
module cfg_cmd_parser
`ifdef CFG_PARSER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input logic              clk,
  input logic              rst_n,
  cfg_cmd_parser_if.master cmd_if
);
  import cfg_cmd_pkg::*;

  parser_state_e     state_q;
  logic              type_seen_q;
  logic [TYPE_W-1:0] type_q;
  logic [DATA_W-1:0] val1_q;
  cfg_cmd_t          cmd_q;
  logic              cfg_valid_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              busy_q;

`ifdef CFG_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
`endif

  logic              rx_vld_c;
  logic [DATA_W-1:0] rx_byte_c;
  logic              is_digit_c;
  logic              is_term_c;
  logic              is_space_c;
  logic              is_minus_c;
  logic              is_type_c;
  logic              in_val_c;
  logic              val_bad_c;
  logic              acc_clr_c;
  logic              acc_push_c;
  logic              acc_neg_c;
  logic [DATA_W-1:0] acc_value;
  logic [1:0]        acc_cnt;
  logic              acc_neg;
  logic              acc_err;

  assign rx_vld_c   = cmd_if.rx_valid;
  assign rx_byte_c  = cmd_if.rx_data;
  assign is_digit_c = is_digit(rx_byte_c);
  assign is_term_c  = is_term(rx_byte_c);
  assign is_space_c = rx_byte_c == ASCII_SPACE;
  assign is_minus_c = rx_byte_c == ASCII_MINUS;
  assign is_type_c  = is_digit_c && (rx_byte_c <= ASCII_0 + 8'(CFG_TYPE_3));
  assign in_val_c   = (state_q == ST_VAL1) || (state_q == ST_VAL2);
  assign val_bad_c  = (acc_cnt == 2'd0) || acc_err;

  // The accumulator restarts on every space that opens a value.
  assign acc_clr_c  = rx_vld_c && is_space_c &&
                      ((state_q == ST_TYPE) || (state_q == ST_VAL1));
  assign acc_push_c = rx_vld_c && is_digit_c && in_val_c && (acc_cnt != 2'd3);
  assign acc_neg_c  = rx_vld_c && is_minus_c && in_val_c &&
                      (acc_cnt == 2'd0) && !acc_neg;

  dec_accum u_dec_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (acc_clr_c),
    .neg_i   (acc_neg_c),
    .push_i  (acc_push_c),
    .digit_i (rx_byte_c[3:0]),
    .value_o (acc_value),
    .cnt_o   (acc_cnt),
    .neg_o   (acc_neg),
    .err_o   (acc_err)
  );

  // Parser FSM with registered command, ack and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      type_seen_q <= 1'b0;
      type_q      <= CFG_TYPE_0;
      val1_q      <= '0;
      cmd_q       <= '0;
      cfg_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
`ifdef CFG_PARSER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      cfg_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_vld_c && (rx_byte_c == ASCII_C)) begin
            state_q     <= ST_TYPE;
            busy_q      <= 1'b1;
            type_seen_q <= 1'b0;
            type_q      <= CFG_TYPE_0;
            val1_q      <= '0;
          end
        end
        ST_TYPE: begin
          if (rx_vld_c) begin
            if (is_type_c && !type_seen_q) begin
              type_q      <= TYPE_W'(rx_byte_c - ASCII_0);
              type_seen_q <= 1'b1;
            end else if (is_space_c && type_seen_q) begin
              state_q <= ST_VAL1;
            end else if (is_term_c && type_seen_q) begin
              cmd_q       <= '{ctype: type_q, value1: '0, value2: '0};
              cfg_valid_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end else if (is_term_c) begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= ASCII_E;
              state_q    <= ST_RESP;
            end else begin
              state_q <= ST_SKIP;
            end
          end
        end
        ST_VAL1, ST_VAL2: begin
          if (rx_vld_c) begin
            if (is_minus_c) begin
              if ((acc_cnt != 2'd0) || acc_neg) state_q <= ST_SKIP;
            end else if (is_digit_c) begin
              if (acc_cnt == 2'd3) state_q <= ST_SKIP;
            end else if (is_space_c) begin
              if ((state_q == ST_VAL2) || val_bad_c) begin
                state_q <= ST_SKIP;
              end else begin
                val1_q  <= acc_value;
                state_q <= ST_VAL2;
              end
            end else if (is_term_c) begin
              if (val_bad_c) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= ASCII_E;
                state_q    <= ST_RESP;
              end else begin
                cmd_q <= (state_q == ST_VAL1)
                         ? '{ctype: type_q, value1: acc_value, value2: '0}
                         : '{ctype: type_q, value1: val1_q, value2: acc_value};
                cfg_valid_q <= 1'b1;
                state_q     <= ST_ISSUE;
              end
            end else begin
              state_q <= ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (rx_vld_c && is_term_c) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= ASCII_E;
            state_q    <= ST_RESP;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef CFG_PARSER_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        ST_WAIT: begin
          // Error wins when done and error coincide.
          if (cmd_if.config_done || cmd_if.config_error) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= cmd_if.config_error ? ASCII_E : ASCII_K;
            state_q    <= ST_RESP;
          end
`ifdef CFG_PARSER_TIMEOUT_EN
          else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= ASCII_T;
            state_q    <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
`endif
        end
        ST_RESP: begin
          if (cmd_if.tx_ready) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.config_valid  = cfg_valid_q;
  assign cmd_if.config_type   = cmd_q.ctype;
  assign cmd_if.config_value1 = cmd_q.value1;
  assign cmd_if.config_value2 = cmd_q.value2;
  assign cmd_if.tx_valid      = tx_valid_q;
  assign cmd_if.tx_data       = tx_data_q;
  assign cmd_if.busy          = busy_q;

endmodule

// File: tb/tb_cfg_cmd_parser.sv
// Directed bench for cfg_cmd_parser: command vector table plus sequences for
// tx back-pressure, ignored coincident pulse, mid-command reset and timeout.
module tb_cfg_cmd_parser;

  localparam int R_DONE = 0;
  localparam int R_ERR  = 1;
  localparam int R_BOTH = 2;
  localparam int NVEC   = 11;

  typedef struct {
    string      cmd;
    int         resp;
    logic       issue;
    logic [2:0] ctype;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [7:0] tx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   issue_cnt = 0;
  vec_t vecs [NVEC];

  cfg_cmd_parser_if bus ();

  cfg_cmd_parser dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.config_valid === 1'b1) issue_cnt = issue_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse(input logic done, input logic err);
    bus.config_done  = done;
    bus.config_error = err;
    step();
    bus.config_done  = 1'b0;
    bus.config_error = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    base;
    string nm;
    base = issue_cnt;
    nm   = $sformatf("v%0d", idx);
    send_str(v.cmd);
    chk({nm, " valid"}, 32'(bus.config_valid), 32'(v.issue));
    if (v.issue) begin
      chk({nm, " type"}, 32'(bus.config_type), 32'(v.ctype));
      chk({nm, " v1"}, 32'(bus.config_value1), 32'(v.v1));
      chk({nm, " v2"}, 32'(bus.config_value2), 32'(v.v2));
      chk({nm, " tx_early"}, 32'(bus.tx_valid), 32'd0);
      step();
      chk({nm, " valid_drop"}, 32'(bus.config_valid), 32'd0);
      pulse(v.resp != R_ERR, v.resp != R_DONE);
    end
    chk({nm, " tx_valid"}, 32'(bus.tx_valid), 32'd1);
    chk({nm, " tx_data"}, 32'(bus.tx_data), 32'(v.tx));
    step();
    chk({nm, " tx_drop"}, 32'(bus.tx_valid), 32'd0);
    chk({nm, " busy_idle"}, 32'(bus.busy), 32'd0);
    chk({nm, " issues"}, 32'(issue_cnt - base), 32'(v.issue));
    step();
  endtask

  initial begin
    bus.rx_valid     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.config_done  = 1'b0;
    bus.config_error = 1'b0;
    bus.tx_ready     = 1'b1;
    rst_n            = 1'b0;

    vecs[0]  = '{"C0 5\015",        R_DONE, 1'b1, 3'd0, 8'h05, 8'h00, 8'h4B};
    vecs[1]  = '{"C1 -3 7\012",     R_ERR,  1'b1, 3'd1, 8'hFD, 8'h07, 8'h45};
    vecs[2]  = '{"C1 -128 127\015", R_DONE, 1'b1, 3'd1, 8'h80, 8'h7F, 8'h4B};
    vecs[3]  = '{"C0 128\015",      R_DONE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h45};
    vecs[4]  = '{"C0 1234\015",     R_DONE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h45};
    vecs[5]  = '{"xyC9 Z\015",      R_DONE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h45};
    vecs[6]  = '{"\015C3\015",      R_DONE, 1'b1, 3'd3, 8'h00, 8'h00, 8'h4B};
    vecs[7]  = '{"C2 -0 99\015",    R_BOTH, 1'b1, 3'd2, 8'h00, 8'h63, 8'h45};
    vecs[8]  = '{"C1 5 6 7\015",    R_DONE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h45};
    vecs[9]  = '{"C3 -\015",        R_DONE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h45};
    vecs[10] = '{"C2 12-\015",      R_DONE, 1'b0, 3'd0, 8'h00, 8'h00, 8'h45};

    repeat (3) step();
    chk("rst config_valid", 32'(bus.config_valid), 32'd0);
    chk("rst config_type", 32'(bus.config_type), 32'd0);
    chk("rst value1", 32'(bus.config_value1), 32'd0);
    chk("rst value2", 32'(bus.config_value2), 32'd0);
    chk("rst tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Back-pressure: ack must hold while tx_ready is low.
    bus.tx_ready = 1'b0;
    send_str("C0 5\015");
    chk("bp valid", 32'(bus.config_valid), 32'd1);
    step();
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold_valid%0d", k), 32'(bus.tx_valid), 32'd1);
      chk($sformatf("bp hold_data%0d", k), 32'(bus.tx_data), 32'h4B);
      step();
    end
    bus.tx_ready = 1'b1;
    chk("bp last_valid", 32'(bus.tx_valid), 32'd1);
    step();
    chk("bp drop", 32'(bus.tx_valid), 32'd0);
    step();

    // A done pulse alongside config_valid is not a response.
    send_str("C3\015");
    chk("co valid", 32'(bus.config_valid), 32'd1);
    pulse(1'b1, 1'b0);
    repeat (3) step();
    chk("co no_tx", 32'(bus.tx_valid), 32'd0);
    chk("co busy", 32'(bus.busy), 32'd1);
    pulse(1'b0, 1'b1);
    chk("co tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("co tx_data", 32'(bus.tx_data), 32'h45);
    step();
    chk("co drop", 32'(bus.tx_valid), 32'd0);
    step();

    // Reset in the middle of a command.
    send_str("C0 1");
    chk("mr busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr config_valid", 32'(bus.config_valid), 32'd0);
    chk("mr config_type", 32'(bus.config_type), 32'd0);
    chk("mr value1", 32'(bus.config_value1), 32'd0);
    chk("mr value2", 32'(bus.config_value2), 32'd0);
    chk("mr tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mr tx_data", 32'(bus.tx_data), 32'd0);
    chk("mr busy", 32'(bus.busy), 32'd0);
    step();
    rst_n = 1'b1;
    begin
      int base;
      base = issue_cnt;
      send_str("2\015");
      repeat (3) step();
      chk("mr tail_issues", 32'(issue_cnt - base), 32'd0);
      chk("mr tail_tx", 32'(bus.tx_valid), 32'd0);
      chk("mr tail_busy", 32'(bus.busy), 32'd0);
    end
    send_str("C2 30\015");
    chk("mr2 valid", 32'(bus.config_valid), 32'd1);
    chk("mr2 type", 32'(bus.config_type), 32'd2);
    chk("mr2 v1", 32'(bus.config_value1), 32'h1E);
    chk("mr2 v2", 32'(bus.config_value2), 32'h00);
    step();
    pulse(1'b1, 1'b0);
    chk("mr2 tx_data", 32'(bus.tx_data), 32'h4B);
    step();
    chk("mr2 drop", 32'(bus.tx_valid), 32'd0);
    step();

`ifdef CFG_PARSER_TIMEOUT_EN
    // Terminator at edge N, WAIT from N+1, 'T' loaded at edge N+17.
    send_str("C1 2\015");
    repeat (16) step();
    chk("to early", 32'(bus.tx_valid), 32'd0);
    step();
    chk("to tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("to tx_data", 32'(bus.tx_data), 32'h54);
    step();
    chk("to drop", 32'(bus.tx_valid), 32'd0);
    step();
    send_str("C1 2\015");
    repeat (16) step();
    pulse(1'b1, 1'b0);
    chk("to last_cycle_done", 32'(bus.tx_data), 32'h4B);
    step();
    chk("to2 drop", 32'(bus.tx_valid), 32'd0);
    step();
`else
    send_str("C1 2\015");
    repeat (100) step();
    chk("nt busy", 32'(bus.busy), 32'd1);
    chk("nt no_tx", 32'(bus.tx_valid), 32'd0);
    pulse(1'b1, 1'b0);
    chk("nt tx_data", 32'(bus.tx_data), 32'h4B);
    step();
    chk("nt drop", 32'(bus.tx_valid), 32'd0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
